c28soi_pm_control_lr_async_promip_freq_checker: RTL and testbench



---
 rtl/c28soi_pm_control_lr_async_promip_pkg.sv | 6 +
 rtl/c28soi_pm_control_lr_async_promip_freq_checker_if.sv | 24 ++
 rtl/c28soi_pm_control_lr_async_promip_sync2.sv | 14 +
 rtl/c28soi_pm_control_lr_async_promip_freq_checker.sv | 107 ++++++++++
 tb/tb_c28soi_pm_control_lr_async_promip_freq_checker.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/c28soi_pm_control_lr_async_promip_pkg.sv
// c28soi_pm_control_lr_async_promip_pkg: FSM state encoding and default widths shared by the promip frequency checker
package c28soi_pm_control_lr_async_promip_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, MEAS = 2'd2, DONE = 2'd3} state_t;
    localparam int CNT_W_DEF = 16;
    localparam int WIN_W_DEF = 16;
endpackage

// File: rtl/c28soi_pm_control_lr_async_promip_freq_checker_if.sv
// c28soi_pm_control_lr_async_promip_freq_checker_if: request/result bundle of the frequency checker
// master drives start, win_len, min_cnt, max_cnt and receives busy, done, edge_cnt, in_range, too_slow, too_fast;
// slave is the checker side
interface c28soi_pm_control_lr_async_promip_freq_checker_if
    import c28soi_pm_control_lr_async_promip_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int WIN_W = WIN_W_DEF
);
    logic             start;
    logic [WIN_W-1:0] win_len;
    logic [CNT_W-1:0] min_cnt;
    logic [CNT_W-1:0] max_cnt;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] edge_cnt;
    logic             in_range;
    logic             too_slow;
    logic             too_fast;
    modport master (output start, win_len, min_cnt, max_cnt,
                    input busy, done, edge_cnt, in_range, too_slow, too_fast);
    modport slave (input start, win_len, min_cnt, max_cnt,
                   output busy, done, edge_cnt, in_range, too_slow, too_fast);
endinterface

// File: rtl/c28soi_pm_control_lr_async_promip_sync2.sv
// c28soi_pm_control_lr_async_promip_sync2: two-flop synchronizer with async active-low reset to 0
// ports: clk, rst_n, d (asynchronous input), q (synchronized output)
module c28soi_pm_control_lr_async_promip_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) {q, meta} <= 2'b00;
        else        {q, meta} <= {meta, d};
    end
endmodule

// File: rtl/c28soi_pm_control_lr_async_promip_freq_checker.sv
// c28soi_pm_control_lr_async_promip_freq_checker: counts div_in rising edges over a clk window and checks a min/max band
// ports: clk, rst_n (async active-low), div_in (async clock under test), bus (slave: start/win_len/min_cnt/max_cnt in,
// busy/done/edge_cnt/in_range/too_slow/too_fast out); with PROMIP_FREQCHK_STICKY_EN also err_clr in, err_sticky out
module c28soi_pm_control_lr_async_promip_freq_checker
    import c28soi_pm_control_lr_async_promip_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int WIN_W = WIN_W_DEF
) (
    input logic clk,
    input logic rst_n,
    input logic div_in,
    c28soi_pm_control_lr_async_promip_freq_checker_if.slave bus
`ifdef PROMIP_FREQCHK_STICKY_EN
    , input  logic err_clr,
    output logic err_sticky
`endif
);
    state_t           state_q, state_d;
    logic             s2, s3, rise, fin, slow_d, fast_d;
    logic [WIN_W-1:0] win_q, win_d, len_q, len_in;
    logic [CNT_W-1:0] cnt_q, cnt_d, min_q, max_q, edge_q;
    logic             in_q, slow_q, fast_q;

    c28soi_pm_control_lr_async_promip_sync2 u_sync (.clk, .rst_n, .d(div_in), .q(s2));

    assign rise   = s2 & ~s3;
    assign len_in = bus.win_len == '0 ? WIN_W'(1) : bus.win_len;
    // fin is the cycle entering DONE; results use the count including this cycle's edge
    assign fin    = state_d == DONE;
    assign slow_d = cnt_d < min_q;
    assign fast_d = cnt_d > max_q;

    // win_q doubles as the ARM timeout and the MEAS window counter
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d = ARM;
                win_d   = len_in;
                cnt_d   = '0;
            end
            ARM: begin
                if (rise) begin
                    state_d = MEAS;
                    win_d   = len_q;
                end else if (win_q == WIN_W'(1)) state_d = DONE;
                else win_d = win_q - 1'b1;
            end
            MEAS: begin
                win_d = win_q - 1'b1;
                cnt_d = rise && cnt_q != '1 ? cnt_q + 1'b1 : cnt_q;
                if (win_q == WIN_W'(1)) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s3      <= 1'b0;
            win_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            min_q   <= '0;
            max_q   <= '0;
            edge_q  <= '0;
            in_q    <= 1'b0;
            slow_q  <= 1'b0;
            fast_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s3      <= s2;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && bus.start) begin
                len_q <= len_in;
                min_q <= bus.min_cnt;
                max_q <= bus.max_cnt;
            end
            if (fin) begin
                edge_q <= cnt_d;
                in_q   <= !slow_d && !fast_d;
                slow_q <= slow_d;
                fast_q <= fast_d;
            end
        end
    end

`ifdef PROMIP_FREQCHK_STICKY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      err_sticky <= 1'b0;
        else if (fin && (slow_d || fast_d)) err_sticky <= 1'b1;
        else if (err_clr)                err_sticky <= 1'b0;
    end
`endif

    assign bus.busy     = state_q != IDLE;
    assign bus.done     = state_q == DONE;
    assign bus.edge_cnt = edge_q;
    assign bus.in_range = in_q;
    assign bus.too_slow = slow_q;
    assign bus.too_fast = fast_q;
endmodule

// File: tb/tb_c28soi_pm_control_lr_async_promip_freq_checker.sv
// tb_c28soi_pm_control_lr_async_promip_freq_checker: directed table plus corner sequences for the frequency checker
module tb_c28soi_pm_control_lr_async_promip_freq_checker;
    logic clk, rst_n, div_in;
    int   half, checks, failures, done_cnt, d0, lat;
`ifdef PROMIP_FREQCHK_STICKY_EN
    logic err_clr, err_sticky, s_err_sticky;
`endif

    c28soi_pm_control_lr_async_promip_freq_checker_if #(.CNT_W(16), .WIN_W(16)) bus ();
    c28soi_pm_control_lr_async_promip_freq_checker_if #(.CNT_W(4), .WIN_W(16)) sbus ();

    c28soi_pm_control_lr_async_promip_freq_checker #(.CNT_W(16), .WIN_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .div_in(div_in), .bus(bus)
`ifdef PROMIP_FREQCHK_STICKY_EN
        , .err_clr(err_clr), .err_sticky(err_sticky)
`endif
    );

    c28soi_pm_control_lr_async_promip_freq_checker #(.CNT_W(4), .WIN_W(16)) dut_small (
        .clk(clk), .rst_n(rst_n), .div_in(div_in), .bus(sbus)
`ifdef PROMIP_FREQCHK_STICKY_EN
        , .err_clr(err_clr), .err_sticky(s_err_sticky)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // div_in toggles every 'half' time units, offset from clk edges; half==0 holds it low
    initial begin
        div_in = 1'b0;
        #3;
        forever begin
            if (half == 0) begin
                div_in = 1'b0;
                @(half);
            end else begin
                #(half) div_in = ~div_in;
            end
        end
    end

    always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

    typedef struct {
        int          half;
        logic [15:0] len, mn, mx, cnt;
        logic        in_r, slow, fast;
        int          lat;
    } vec_t;
    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic run(input logic [15:0] len, input logic [15:0] mn, input logic [15:0] mx, output int l);
        repeat (10) @(negedge clk);
        bus.win_len = len;
        bus.min_cnt = mn;
        bus.max_cnt = mx;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        l = 1;
        while (bus.done !== 1'b1 && l < 2000) begin
            @(negedge clk);
            l++;
        end
        chk("done_seen", {31'b0, bus.done}, 1);
    endtask

    initial begin
        checks = 0; failures = 0; done_cnt = 0; half = 20;
        vecs[0] = '{20, 16'd100, 16'd20, 16'd30, 16'd25, 1'b1, 1'b0, 1'b0, 0};
        vecs[1] = '{0,  16'd50,  16'd20, 16'd30, 16'd0,  1'b0, 1'b1, 1'b0, 51};
        vecs[2] = '{10, 16'd100, 16'd40, 16'd60, 16'd50, 1'b1, 1'b0, 1'b0, 0};
        vecs[3] = '{20, 16'd8,   16'd2,  16'd2,  16'd2,  1'b1, 1'b0, 1'b0, 0};
        vecs[4] = '{20, 16'd0,   16'd0,  16'd0,  16'd0,  1'b1, 1'b0, 1'b0, 0};
        vecs[5] = '{20, 16'd40,  16'd12, 16'd5,  16'd10, 1'b0, 1'b1, 1'b1, 0};
        vecs[6] = '{20, 16'd100, 16'd25, 16'd25, 16'd25, 1'b1, 1'b0, 1'b0, 0};
        vecs[7] = '{20, 16'd100, 16'd26, 16'd30, 16'd25, 1'b0, 1'b1, 1'b0, 0};
        vecs[8] = '{20, 16'd100, 16'd10, 16'd24, 16'd25, 1'b0, 1'b0, 1'b1, 0};
        vecs[9] = '{10, 16'd6,   16'd3,  16'd3,  16'd3,  1'b1, 1'b0, 1'b0, 0};
        rst_n = 1'b0;
        bus.start = 1'b0;  bus.win_len = '0;  bus.min_cnt = '0;  bus.max_cnt = '0;
        sbus.start = 1'b0; sbus.win_len = '0; sbus.min_cnt = '0; sbus.max_cnt = '0;
`ifdef PROMIP_FREQCHK_STICKY_EN
        err_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, bus.busy}, 0);
        chk("rst_done", {31'b0, bus.done}, 0);
        chk("rst_edge_cnt", {16'b0, bus.edge_cnt}, 0);
        chk("rst_in_range", {31'b0, bus.in_range}, 0);
        chk("rst_too_slow", {31'b0, bus.too_slow}, 0);
        chk("rst_too_fast", {31'b0, bus.too_fast}, 0);
        chk("rst_small_edge_cnt", {28'b0, sbus.edge_cnt}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            half = vecs[i].half;
            d0 = done_cnt;
            run(vecs[i].len, vecs[i].mn, vecs[i].mx, lat);
            chk($sformatf("v%0d_edge_cnt", i), {16'b0, bus.edge_cnt}, {16'b0, vecs[i].cnt});
            chk($sformatf("v%0d_in_range", i), {31'b0, bus.in_range}, {31'b0, vecs[i].in_r});
            chk($sformatf("v%0d_too_slow", i), {31'b0, bus.too_slow}, {31'b0, vecs[i].slow});
            chk($sformatf("v%0d_too_fast", i), {31'b0, bus.too_fast}, {31'b0, vecs[i].fast});
            if (vecs[i].lat != 0) chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            @(negedge clk);
            chk($sformatf("v%0d_busy_after", i), {31'b0, bus.busy}, 0);
            chk($sformatf("v%0d_one_done", i), done_cnt - d0, 1);
        end

        // start re-pulsed mid-measurement and win_len changed after start: both ignored
        half = 20;
        d0 = done_cnt;
        repeat (10) @(negedge clk);
        bus.win_len = 16'd40; bus.min_cnt = 16'd5; bus.max_cnt = 16'd15; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.win_len = 16'd8;
        repeat (15) @(negedge clk);
        chk("ign_busy_mid", {31'b0, bus.busy}, 1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (60) @(negedge clk);
        chk("ign_one_done", done_cnt - d0, 1);
        chk("ign_edge_cnt", {16'b0, bus.edge_cnt}, 10);
        chk("ign_busy_end", {31'b0, bus.busy}, 0);

        // async reset mid-measurement aborts and clears results
        repeat (10) @(negedge clk);
        bus.win_len = 16'd100; bus.min_cnt = 16'd20; bus.max_cnt = 16'd30; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        d0 = done_cnt;
        #1;
        chk("abort_busy", {31'b0, bus.busy}, 0);
        chk("abort_edge_cnt", {16'b0, bus.edge_cnt}, 0);
        chk("abort_done", {31'b0, bus.done}, 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (120) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        run(16'd100, 16'd20, 16'd30, lat);
        chk("post_abort_edge_cnt", {16'b0, bus.edge_cnt}, 25);
        chk("post_abort_in_range", {31'b0, bus.in_range}, 1);

        // narrow counter saturates at all-ones
        half = 10;
        repeat (10) @(negedge clk);
        sbus.win_len = 16'd100; sbus.min_cnt = 4'd0; sbus.max_cnt = 4'd10; sbus.start = 1'b1;
        @(negedge clk);
        sbus.start = 1'b0;
        lat = 1;
        while (sbus.done !== 1'b1 && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
        chk("sat_done_seen", {31'b0, sbus.done}, 1);
        chk("sat_edge_cnt", {28'b0, sbus.edge_cnt}, 15);
        chk("sat_too_fast", {31'b0, sbus.too_fast}, 1);
        chk("sat_in_range", {31'b0, sbus.in_range}, 0);
        chk("sat_too_slow", {31'b0, sbus.too_slow}, 0);
`ifdef PROMIP_FREQCHK_STICKY_EN
        chk("sat_sticky", {31'b0, s_err_sticky}, 1);
        half = 20;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("sticky_cleared", {31'b0, err_sticky}, 0);
        run(16'd100, 16'd26, 16'd30, lat);
        chk("sticky_set_on_fail", {31'b0, err_sticky}, 1);
        run(16'd100, 16'd20, 16'd30, lat);
        chk("sticky_held_on_pass", {31'b0, err_sticky}, 1);
        err_clr = 1'b1;
        run(16'd100, 16'd26, 16'd30, lat);
        chk("sticky_set_wins", {31'b0, err_sticky}, 1);
        err_clr = 1'b0;
        @(negedge clk);
        chk("sticky_after_win", {31'b0, err_sticky}, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("sticky_final_clear", {31'b0, err_sticky}, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
